// File: rtl/utx_arb_if.sv
// Requester/PHY-side bundle for utx_arb: byte lanes with req/ack, and the PHY tx strobe.
// master: requesters side (drives req/data); slave: the arbiter.
interface utx_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_vld;
  logic              busy;
  logic [IW-1:0]     grant_idx;
  logic [15:0]       tx_cnt;

  modport master (
    output req, data,
    input  ack, tx_data, tx_vld, busy, grant_idx, tx_cnt
  );

  modport slave (
    input  req, data,
    output ack, tx_data, tx_vld, busy, grant_idx, tx_cnt
  );
endinterface

// File: rtl/utx_arb.sv
// utx_arb: round-robin arbiter sharing one UART TX PHY between NREQ byte sources.
// One byte per grant, then a FRAME_US pluse_us hold-off so a PHY frame is never cut short.
// Optional build macro UTX_ARB_HIPRI_EN: lane 0 pre-empts the rotation; lanes 1..NREQ-1
// rotate among themselves. Lane 0 cannot take two consecutive slots while another lane waits.
module utx_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned FRAME_US = 100,
  parameter int unsigned IW       = 2
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         pluse_us,
  utx_arb_if.slave     bus
);

  localparam int unsigned CW = $clog2(FRAME_US);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            tx_vld_q, tx_vld_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   grant_idx_q, grant_idx_d;
  logic [15:0]     tx_cnt_q, tx_cnt_d;
`ifdef UTX_ARB_HIPRI_EN
  logic [IW-1:0]   rr_q, rr_d;
`endif

  logic [7:0]      lane_c [NREQ];
  logic [IW-1:0]   pick_c;
  logic            pick_vld_c;

  // Unpack the flattened byte lanes
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign lane_c[g] = bus.data[g*8 +: 8];
  end

`ifdef UTX_ARB_HIPRI_EN
  // Lane 0 first unless it took the previous slot; otherwise rotate over lanes 1..NREQ-1
  always_comb begin
    logic [IW-1:0] idx;
    logic          rr_vld;
    logic [IW-1:0] rr_pick;
    idx        = '0;
    rr_vld     = 1'b0;
    rr_pick    = '0;
    pick_c     = '0;
    pick_vld_c = 1'b0;
    for (int unsigned k = 1; k < NREQ; k++) begin
      idx = IW'(32'd1 + ((32'(rr_q) - 32'd1 + k) % (NREQ - 32'd1)));
      if (!rr_vld && bus.req[idx]) begin
        rr_pick = idx;
        rr_vld  = 1'b1;
      end
    end
    if (bus.req[0] && (grant_idx_q != '0 || !rr_vld)) begin
      pick_c     = '0;
      pick_vld_c = 1'b1;
    end else if (rr_vld) begin
      pick_c     = rr_pick;
      pick_vld_c = 1'b1;
    end
  end
`else
  // First requesting lane scanning grant_idx+1, +2, ... modulo NREQ
  always_comb begin
    logic [IW-1:0] idx;
    idx        = '0;
    pick_c     = '0;
    pick_vld_c = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(grant_idx_q) + k) % NREQ);
      if (!pick_vld_c && bus.req[idx]) begin
        pick_c     = idx;
        pick_vld_c = 1'b1;
      end
    end
  end
`endif

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    tx_vld_d    = tx_vld_q;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    grant_idx_d = grant_idx_q;
    tx_cnt_d    = tx_cnt_q;
`ifdef UTX_ARB_HIPRI_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_c) begin
          state_d     = ST_WAIT;
          cnt_d       = '0;
          tx_vld_d    = 1'b1;
          tx_data_d   = lane_c[pick_c];
          ack_d       = NREQ'(1) << pick_c;
          grant_idx_d = pick_c;
          tx_cnt_d    = tx_cnt_q + 16'd1;
          busy_d      = 1'b1;
`ifdef UTX_ARB_HIPRI_EN
          if (pick_c != '0) rr_d = pick_c;
`endif
        end
      end
      ST_WAIT: begin
        tx_vld_d = 1'b0;
        ack_d    = '0;
        if (pluse_us) begin
          if (cnt_q == CW'(FRAME_US - 1)) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset overrides everything, including mid-frame
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ack_q       <= '0;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      grant_idx_q <= IW'(NREQ - 1);
      tx_cnt_q    <= 16'h0000;
`ifdef UTX_ARB_HIPRI_EN
      rr_q        <= IW'(NREQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      tx_vld_q    <= tx_vld_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      grant_idx_q <= grant_idx_d;
      tx_cnt_q    <= tx_cnt_d;
`ifdef UTX_ARB_HIPRI_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.tx_vld    = tx_vld_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = busy_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.tx_cnt    = tx_cnt_q;

endmodule

// File: tb/tb_utx_arb.sv
// Directed bench for utx_arb (NREQ=4, FRAME_US=100); expected values are hand-computed.
module tb_utx_arb;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned FRAME_US = 100;
  localparam int unsigned IW       = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pluse_us = 1'b1;

  int unsigned pdiv   = 1;
  int unsigned pphase = 0;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          ack_bad = 0;

  utx_arb_if #(.NREQ(NREQ), .IW(IW)) bus ();

  utx_arb #(.NREQ(NREQ), .FRAME_US(FRAME_US), .IW(IW)) dut (
    .clk_sys  (clk),
    .rst      (rst),
    .pluse_us (pluse_us),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it differs
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs sampled 1 time unit after the edge; ack must only pulse with tx_vld
  task automatic step();
    @(posedge clk);
    #1;
    pphase++;
    pluse_us = ((pphase % pdiv) == 0);
    if (bus.ack != '0 && !bus.tx_vld) ack_bad++;
  endtask

  // Step until tx_vld is seen, returning the number of cycles taken
  task automatic wait_vld(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (1) begin
      step();
      cyc++;
      if (bus.tx_vld) break;
      if (cyc >= budget) begin
        chk({tag, " tx_vld timeout"}, 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " tx_vld"},    32'(bus.tx_vld),    32'd0);
    chk({tag, " ack"},       32'(bus.ack),       32'd0);
    chk({tag, " tx_data"},   32'(bus.tx_data),   32'h00);
    chk({tag, " busy"},      32'(bus.busy),      32'd0);
    chk({tag, " grant_idx"}, 32'(bus.grant_idx), 32'd3);
    chk({tag, " tx_cnt"},    32'(bus.tx_cnt),    32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    int pc;
    int exp_g [5];
`ifdef UTX_ARB_HIPRI_EN
    exp_g = '{0, 1, 0, 2, 0};
`else
    exp_g = '{0, 1, 2, 3, 0};
`endif
    bus.req  = '0;
    bus.data = '0;

    // Reset values
    do_reset();
    chk_reset_vals("reset");

    // Single byte from lane 0, then one full frame of hold-off
    bus.data = {8'h00, 8'h00, 8'h00, 8'hA5};
    bus.req  = 4'b0001;
    wait_vld("t1", 3, cyc);
    chk("t1 latency", 32'(cyc), 32'd1);
    chk("t1 tx_data", 32'(bus.tx_data), 32'hA5);
    chk("t1 ack", 32'(bus.ack), 32'b0001);
    chk("t1 busy", 32'(bus.busy), 32'd1);
    chk("t1 tx_cnt", 32'(bus.tx_cnt), 32'd1);
    chk("t1 grant_idx", 32'(bus.grant_idx), 32'd0);
    bus.req = '0;
    n = 0;
    while (bus.busy && n < 300) begin
      step();
      n++;
      if (n == 1) chk("t1 tx_vld pulse width", 32'(bus.tx_vld), 32'd0);
    end
    chk("t1 hold-off cycles", 32'(n), 32'd100);

    // All lanes requesting continuously: rotation order and spacing
    do_reset();
    bus.data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_vld($sformatf("t2 grant%0d", i), 200, cyc);
      chk($sformatf("t2 spacing%0d", i), 32'(cyc), (i == 0) ? 32'd1 : 32'd101);
      chk($sformatf("t2 grant_idx%0d", i), 32'(bus.grant_idx), 32'(exp_g[i]));
      chk($sformatf("t2 tx_data%0d", i), 32'(bus.tx_data), 32'h10 + 32'(exp_g[i]));
      chk($sformatf("t2 ack%0d", i), 32'(bus.ack), 32'd1 << exp_g[i]);
    end
    chk("t2 tx_cnt", 32'(bus.tx_cnt), 32'd5);

    // Lane 2 alone, lane 1 rises during the hold-off and waits for it to end
    do_reset();
    bus.data = {8'h33, 8'h22, 8'h21, 8'h20};
    bus.req  = 4'b0100;
    wait_vld("t3a", 3, cyc);
    chk("t3 first grant", 32'(bus.grant_idx), 32'd2);
    chk("t3 first data", 32'(bus.tx_data), 32'h22);
    bus.req = 4'b0000;
    for (int i = 0; i < 10; i++) step();
    bus.req = 4'b0010;
    wait_vld("t3b", 200, cyc);
    chk("t3 wait cycles", 32'(cyc), 32'd91);
    chk("t3 second grant", 32'(bus.grant_idx), 32'd1);
    chk("t3 second data", 32'(bus.tx_data), 32'h21);
    chk("t3 tx_cnt", 32'(bus.tx_cnt), 32'd2);

    // Reset halfway through the hold-off aborts it
    bus.req = 4'b0000;
    for (int i = 0; i < 50; i++) step();
    chk("t4 busy before rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    chk_reset_vals("t4 mid-frame rst");
    rst = 1'b0;
    bus.req = 4'b0010;
    step();
    chk("t4 tx_vld after rst", 32'(bus.tx_vld), 32'd1);
    chk("t4 tx_cnt", 32'(bus.tx_cnt), 32'd1);
    chk("t4 grant_idx", 32'(bus.grant_idx), 32'd1);
    chk("t4 ack", 32'(bus.ack), 32'b0010);
    bus.req = 4'b0000;

    // Sparse pluse_us: the hold-off counts strobes, not clocks
    do_reset();
    pdiv = 3;
    bus.req = 4'b1000;
    wait_vld("t5", 5, cyc);
    chk("t5 grant_idx", 32'(bus.grant_idx), 32'd3);
    chk("t5 tx_data", 32'(bus.tx_data), 32'h33);
    bus.req = 4'b0000;
    pc = 0;
    n  = 0;
    while (bus.busy && n < 400) begin
      if (pluse_us) pc++;
      step();
      n++;
    end
    chk("t5 pulses in hold-off", 32'(pc), 32'd100);
    chk("t5 busy dropped", 32'(bus.busy), 32'd0);
    chk("t5 tx_cnt", 32'(bus.tx_cnt), 32'd1);

    chk("ack only with tx_vld", 32'(ack_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
